// File: rtl/collatz_pkg.sv
// Shared constants, control-bit positions and FSM encoding for the Collatz
// sweeper and its best-orbit tracker.
package collatz_pkg;
   localparam int unsigned BITS      = 144;
   localparam int unsigned BYTES     = BITS / 8;
   localparam int unsigned ADDR_BITS = 5;
   localparam int unsigned OLEN_BITS = 16;

   localparam logic [31:0] OVERFLOW_MARKER = 32'hBAADF00D;

   // core_uio_in control bits
   localparam int unsigned WE = 7;
   localparam int unsigned GO = 6;
   localparam int unsigned PR = 5;

   localparam int unsigned SETTLE_CYCLES = 2;
   localparam int unsigned READ_CYCLES   = 7;

   localparam logic [1:0] ERR_OK       = 2'd0;
   localparam logic [1:0] ERR_OVERFLOW = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

   typedef enum logic [2:0] {
      IDLE, WRITE, KICK, SETTLE, WAIT, READ, EVAL, FIN
   } state_t;
endpackage

// File: rtl/collatz_sweeper_if.sv
// Pin-level bus between the sweeper and a Collatz core.
interface collatz_sweeper_if;
   logic [7:0] core_ui_in;
   logic [7:0] core_uio_in;
   logic [7:0] core_uo_out;
   logic [7:0] core_uio_out;

   modport master (
      output core_ui_in, core_uio_in,
      input  core_uo_out, core_uio_out
   );

   modport slave (
      input  core_ui_in, core_uio_in,
      output core_uo_out, core_uio_out
   );
endinterface

// File: rtl/collatz_best_tracker.sv
// Turns the core's cumulative orbit length into per-seed lengths and keeps
// the seed with the longest orbit (earliest seed wins ties).
module collatz_best_tracker
   import collatz_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 eval,
   input  logic [31:0]          cur_seed,
   input  logic [OLEN_BITS-1:0] len_now,
   output logic [31:0]          best_seed,
   output logic [OLEN_BITS-1:0] best_len
);
   logic [OLEN_BITS-1:0] len_prev;
   logic [OLEN_BITS-1:0] delta;

   // The core never clears its length counter, so len_prev survives across sweeps.
   always_comb delta = len_now - len_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         len_prev  <= '0;
         best_seed <= '0;
         best_len  <= '0;
      end else if (clear) begin
         best_seed <= '0;
         best_len  <= '0;
      end else if (eval) begin
         len_prev <= len_now;
         if (delta > best_len) begin
            best_seed <= cur_seed;
            best_len  <= delta;
         end
      end
   end
endmodule

// File: rtl/collatz_sweeper.sv
// Sweeps a range of seeds through an external Collatz core and reports the
// seed with the longest orbit, flagging core overflow and busy timeouts.
module collatz_sweeper
   import collatz_pkg::*;
#(
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [31:0]          seed,
   input  logic [15:0]          count,
   collatz_sweeper_if.master    core,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           error,
   output logic [31:0]          best_seed,
   output logic [OLEN_BITS-1:0] best_len
);
   state_t               state, next_state;
   logic [ADDR_BITS-1:0] step;
   logic [31:0]          wait_cnt;
   logic [31:0]          cur_seed;
   logic [31:0]          path;
   logic [15:0]          remaining;
   logic [OLEN_BITS-1:0] len_now;
   logic                 accept, core_busy, wait_expired, overflow;

   assign accept       = (state == IDLE) && start;
   assign core_busy    = core.core_uio_out[7];
   assign wait_expired = wait_cnt == 32'(TIMEOUT - 1);
   assign overflow     = path == OVERFLOW_MARKER;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = (count == '0) ? FIN : WRITE;
         WRITE:   if (step == ADDR_BITS'(BYTES - 1)) next_state = KICK;
         KICK:    next_state = SETTLE;
         SETTLE:  if (step == ADDR_BITS'(SETTLE_CYCLES - 1)) next_state = WAIT;
         WAIT:    if (!core_busy) next_state = READ;
                  else if (wait_expired) next_state = FIN;
         READ:    if (step == ADDR_BITS'(READ_CYCLES - 1)) next_state = EVAL;
         EVAL:    next_state = (overflow || remaining == 16'd1) ? FIN : WRITE;
         FIN:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      core.core_ui_in  = '0;
      core.core_uio_in = '0;
      busy = state != IDLE;
      done = state == FIN;
      case (state)
         WRITE: begin
            core.core_uio_in[WE]            = 1'b1;
            core.core_uio_in[ADDR_BITS-1:0] = step;
            if (step < 5'd4) core.core_ui_in = cur_seed[{step[1:0], 3'b000} +: 8];
         end
         KICK: core.core_uio_in[GO] = 1'b1;
         // Length bytes 0..1, then path-record bytes 0..3; the last cycle only captures.
         READ: begin
            if (step < 5'd2) begin
               core.core_uio_in[ADDR_BITS-1:0] = step;
            end else if (step < 5'd6) begin
               core.core_uio_in[PR]            = 1'b1;
               core.core_uio_in[ADDR_BITS-1:0] = step - 5'd2;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         step      <= '0;
         wait_cnt  <= '0;
         cur_seed  <= '0;
         remaining <= '0;
         len_now   <= '0;
         path      <= '0;
         error     <= ERR_OK;
      end else begin
         step     <= (next_state == state) ? step + 1'b1 : '0;
         wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
         case (state)
            IDLE: if (start) begin
               cur_seed  <= seed;
               remaining <= count;
               error     <= ERR_OK;
            end
            WAIT: if (core_busy && wait_expired) error <= ERR_TIMEOUT;
            // Read data lags the driven address by one cycle.
            READ: case (step)
               5'd1:    len_now[7:0]  <= core.core_uo_out;
               5'd2:    len_now[15:8] <= core.core_uo_out;
               5'd3:    path[7:0]     <= core.core_uo_out;
               5'd4:    path[15:8]    <= core.core_uo_out;
               5'd5:    path[23:16]   <= core.core_uo_out;
               5'd6:    path[31:24]   <= core.core_uo_out;
               default: ;
            endcase
            EVAL: begin
               if (overflow) error <= ERR_OVERFLOW;
               cur_seed  <= cur_seed + 32'd1;
               remaining <= remaining - 16'd1;
            end
            default: ;
         endcase
      end
   end

   collatz_best_tracker u_tracker (
      .clk       (clk),
      .reset     (reset),
      .clear     (accept),
      .eval      ((state == EVAL) && !overflow),
      .cur_seed  (cur_seed),
      .len_now   (len_now),
      .best_seed (best_seed),
      .best_len  (best_len)
   );
endmodule

// File: tb/tb_collatz_sweeper.sv
// Scoreboard bench: sweeper paired with a behavioural Collatz core model,
// directed orbit cases, random sweeps, overflow/timeout stubs and resets.
module tb_collatz_sweeper;
   import collatz_pkg::*;

   localparam int unsigned TIMEOUT = 100;

   typedef struct packed {
      logic [31:0] bs;
      logic [15:0] bl;
      logic [1:0]  err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [31:0] seed;
   logic [15:0] count;
   logic        busy, done;
   logic [1:0]  error;
   logic [31:0] best_seed;
   logic [15:0] best_len;

   collatz_sweeper_if bus ();

   collatz_sweeper #(.TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .seed      (seed),
      .count     (count),
      .core      (bus),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .best_seed (best_seed),
      .best_len  (best_len)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int done_seen = 0, kicks = 0, cyc = 0, kick_cyc = 0, done_cyc = 0;
   exp_t exp_q[$];

   // Reference arithmetic: steps to reach 1, and the peak value on the way.
   function automatic int unsigned orbit_steps(input longint unsigned n0);
      longint unsigned n = n0;
      int unsigned s = 0;
      while (n > 1 && s < 5000) begin
         n = n[0] ? 3 * n + 1 : n >> 1;
         s++;
      end
      return s;
   endfunction

   function automatic longint unsigned orbit_peak(input longint unsigned n0);
      longint unsigned n = n0, pk = n0;
      int unsigned s = 0;
      while (n > 1 && s < 5000) begin
         n = n[0] ? 3 * n + 1 : n >> 1;
         if (n > pk) pk = n;
         s++;
      end
      return pk;
   endfunction

   function automatic exp_t model(input logic [31:0] s, input logic [15:0] c);
      exp_t e = '0;
      for (int i = 0; i < int'(c); i++) begin
         int unsigned st = orbit_steps(longint'(s + 32'(i)));
         if (st > int'(e.bl)) begin
            e.bs = s + 32'(i);
            e.bl = 16'(st);
         end
      end
      return e;
   endfunction

   // Behavioural core: 144-bit register (low 64 bits modelled), cumulative length.
   logic [7:0]  core_reg [32];
   logic [15:0] olen;
   logic [31:0] core_pr;
   int unsigned busy_left;
   logic        stub_marker = 1'b0, stub_hold = 1'b0;

   function automatic longint unsigned reg_value();
      longint unsigned v = 0;
      for (int i = 7; i >= 0; i--) v = (v << 8) | longint'(core_reg[i]);
      return v;
   endfunction

   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [4:0] a);
      case (a)
         5'd0:    return w[7:0];
         5'd1:    return w[15:8];
         5'd2:    return w[23:16];
         5'd3:    return w[31:24];
         default: return 8'h00;
      endcase
   endfunction

   assign bus.core_uio_out = {busy_left != 0, 7'b0};

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) core_reg[i] <= 8'hA5;
         olen            <= '0;
         core_pr         <= '0;
         busy_left       <= 0;
         bus.core_uo_out <= '0;
      end else begin
         if (bus.core_uio_in[WE]) core_reg[bus.core_uio_in[4:0]] <= bus.core_ui_in;
         if (bus.core_uio_in[GO]) begin
            olen      <= olen + 16'(orbit_steps(reg_value()));
            core_pr   <= stub_marker ? OVERFLOW_MARKER : 32'(orbit_peak(reg_value()));
            busy_left <= stub_hold ? 1 : orbit_steps(reg_value()) / 4 + 3;
         end else if (busy_left != 0 && !stub_hold) begin
            busy_left <= busy_left - 1;
         end
         bus.core_uo_out <= bus.core_uio_in[PR] ? byte_of(core_pr, bus.core_uio_in[4:0])
                                                : byte_of(32'(olen), bus.core_uio_in[4:0]);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation per done pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.core_uio_in === 8'h40) begin
            kicks++;
            kick_cyc = cyc;
         end
         if (done === 1'b1) begin
            done_seen++;
            done_cyc = cyc;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=done required=no_done");
            end else begin
               e = exp_q.pop_front();
               chk("best_seed", best_seed, e.bs);
               chk("best_len", 32'(best_len), 32'(e.bl));
               chk("error", 32'(error), 32'(e.err));
            end
         end
      end
   end

   task automatic pulse_start(input logic [31:0] s, input logic [15:0] c);
      @(negedge clk);
      seed  = s;
      count = c;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, output int n);
      n = 0;
      while (done_seen == d0 && n < 20000) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (done_seen == d0) begin
         errors++;
         $display("FAIL done_timeout actual=no_done required=done");
         exp_q.delete();
      end
   endtask

   task automatic sweep(input logic [31:0] s, input logic [15:0] c, input exp_t e, output int n);
      int d0 = done_seen;
      exp_q.push_back(e);
      pulse_start(s, c);
      wait_done(d0, n);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic chk_reset_values();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_error", 32'(error), 0);
      chk("rst_best_seed", best_seed, 0);
      chk("rst_best_len", 32'(best_len), 0);
      chk("rst_uio_in", 32'(bus.core_uio_in), 0);
      chk("rst_ui_in", 32'(bus.core_ui_in), 0);
   endtask

   initial begin
      int n, d0, k0, waited;
      logic [31:0] s;
      logic [15:0] c;
      reset = 1'b1;
      start = 1'b0;
      seed  = '0;
      count = '0;
      repeat (3) @(negedge clk);
      chk_reset_values();
      reset = 1'b0;

      sweep(32'd6, 16'd1, '{32'd6, 16'd8, 2'd0}, n);
      sweep(32'd1, 16'd10, '{32'd9, 16'd19, 2'd0}, n);
      sweep(32'd27, 16'd1, '{32'd27, 16'd111, 2'd0}, n);
      sweep(32'd27, 16'd1, '{32'd27, 16'd111, 2'd0}, n);

      for (int i = 0; i < 8; i++) begin
         s = 32'($urandom_range(1, 2000));
         c = 16'($urandom_range(1, 6));
         sweep(s, c, model(s, c), n);
      end

      sweep(32'd55, 16'd0, '{32'd0, 16'd0, 2'd0}, n);
      chk("count0_latency_le2", 32'(n <= 2), 1);

      // Overflow stub: first seed aborts the sweep.
      stub_marker = 1'b1;
      k0 = kicks;
      sweep(32'd7, 16'd5, '{32'd0, 16'd0, 2'd1}, n);
      chk("overflow_kicks", 32'(kicks - k0), 1);
      repeat (5) @(negedge clk);
      chk("overflow_error_held", 32'(error), 1);
      stub_marker = 1'b0;
      apply_reset();

      // Busy-hold stub: timeout after exactly TIMEOUT WAIT cycles; mid-sweep start ignored.
      stub_hold = 1'b1;
      k0 = kicks;
      d0 = done_seen;
      exp_q.push_back('{32'd0, 16'd0, 2'd2});
      pulse_start(32'd5, 16'd3);
      repeat (50) @(negedge clk);
      pulse_start(32'd1000, 16'd1);
      wait_done(d0, n);
      chk("timeout_wait_cycles", 32'(done_cyc - kick_cyc), 32'(TIMEOUT + 3));
      chk("timeout_kicks", 32'(kicks - k0), 1);
      repeat (10) @(negedge clk);
      chk("timeout_single_done", 32'(done_seen - d0), 1);
      stub_hold = 1'b0;
      apply_reset();

      // Reset while the second seed of a sweep is in WAIT.
      k0 = kicks;
      d0 = done_seen;
      pulse_start(32'd9, 16'd3);
      waited = 0;
      while (!(kicks - k0 >= 2 && busy_left != 0) && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      chk("reach_second_wait", 32'(waited < 2000), 1);
      chk("mid_best_len", 32'(best_len), 32'd19);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_values();
      reset = 1'b0;
      repeat (150) @(negedge clk);
      chk("no_done_after_reset", 32'(done_seen - d0), 0);

      sweep(32'd1, 16'd10, '{32'd9, 16'd19, 2'd0}, n);

      repeat (10) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/collatz_sweeper.md
COLLATZ_SWEEPER -- requirements
Module: collatz_sweeper

Interface
REQ-001 Parameter TIMEOUT, default 65535: maximum WAIT cycles per seed before abort.
REQ-002 Port clk, input, 1: sole clock; all logic on posedge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port start, input, 1: one-cycle pulse that begins a sweep; ignored unless state is IDLE.
REQ-005 Port seed, input, 32: first starting value; sampled on an accepted start.
REQ-006 Port count, input, 16: number of consecutive seeds; sampled on an accepted start.
REQ-007 Port core_ui_in, output, 8: data byte to the core's ui_in.
REQ-008 Port core_uio_in, output, 8: control to the core's uio_in; bit7 write, bit6 compute, bit5 path-record select, bits4:0 address.
REQ-009 Port core_uo_out, input, 8: read data from the core.
REQ-010 Port core_uio_out, input, 8: core status; bit7 is busy.
REQ-011 Port busy, output, 1: sweep in progress.
REQ-012 Port done, output, 1: one-cycle pulse at sweep end.
REQ-013 Port error, output, 2: 0 ok, 1 overflow, 2 timeout; held until the next accepted start.
REQ-014 Port best_seed, output, 32: seed with the longest orbit.
REQ-015 Port best_len, output, 16: orbit length of best_seed.

Function
REQ-016 FSM states: IDLE, WRITE, KICK, SETTLE, WAIT, READ, EVAL, FIN.
REQ-017 IDLE + start: latch seed and count, clear best_seed, best_len and error; if count==0 go to FIN, else go to WRITE.
REQ-018 WRITE, 18 cycles, address 0..17: core_uio_in={1,0,0,addr}; core_ui_in = current-seed byte for addr 0..3 (little-endian) and 0x00 for addr 4..17, so all 144 bits of the core's iteration register are overwritten.
REQ-019 KICK, 1 cycle: core_uio_in=0x40; all other states drive core_uio_in bit6=0.
REQ-020 SETTLE, 2 cycles: core_uio_in=0x00; busy is not sampled.
REQ-021 WAIT: core_uio_in=0x00; core_uio_out[7]==0 goes to READ next cycle.
REQ-022 WAIT: after TIMEOUT cycles with busy still high, set error=2 and go to FIN.
REQ-023 READ: drive 6 addresses in order: orbit-length bytes 0,1 (bit5=0), then path-record bytes 0..3 (bit5=1).
REQ-024 READ capture: data for the address driven in cycle t is sampled from core_uo_out in cycle t+1, giving 7 cycles pipelined.
REQ-025 Core orbit length is cumulative, never cleared between runs; delta = len_now - len_prev mod 2^16; len_prev <= len_now after each seed; len_prev = 0 after reset.
REQ-026 EVAL: if the low 32 bits of the path record == 0xBAADF00D, set error=1 and go to FIN; the core stays locked until its own reset.
REQ-027 EVAL: if delta > best_len, update best_seed and best_len; on a tie keep the earlier seed.
REQ-028 EVAL: seed+1 mod 2^32, remaining-1; remaining==0 goes to FIN, else WRITE.
REQ-029 FIN: done=1 for one cycle, then go to IDLE; busy=1 in every state except IDLE.
REQ-030 Combined: start during a non-IDLE state has no effect; start in the same cycle as reset is ignored.

Reset
REQ-031 Reset values: state=IDLE, busy=0, done=0, error=0, best_seed=0, best_len=0, len_prev=0, core_uio_in=0x00, core_ui_in=0x00.
REQ-032 Reset mid-sweep: abandon the sweep in the next cycle with no done pulse; the core must be reset alongside.

Structure
REQ-033 Shared package collatz_pkg holds: BITS=144, BYTES=18, ADDR_BITS=5, OLEN_BITS=16, OVERFLOW_MARKER=32'hBAADF00D, control bit positions (WE=7, GO=6, PR=5), and the FSM state encoding.
REQ-034 Sub-module collatz_best_tracker holds the delta, compare and best registers; the FSM and pin sequencing stay in collatz_sweeper.

Verification
REQ-035 Bench pairs the sweeper with the real collatz core; seed=6, count=1 -> best_seed=6, best_len=8, error=0, one done pulse.
REQ-036 seed=1, count=10 -> best_seed=9, best_len=19, error=0.
REQ-037 Two back-to-back sweeps with no reset, seed=27 count=1 twice -> best_len=111 both times, showing the cumulative-length subtraction works.
REQ-038 Stub core returning 0xBAADF00D for path-record bytes -> error=1, done pulses, sweep stops after the first seed.
REQ-039 Stub core holding busy=1, TIMEOUT=100 -> error=2 after 100 WAIT cycles; start pulsed mid-sweep is ignored.
REQ-040 Reset during WAIT -> all outputs at reset values next cycle and no done pulse; count=0 -> done after 2 cycles with best_len=0.
